// File: rtl/cache_ctrl_dm_if.sv
// Request/response, flush and RAM-side signals of the direct-mapped cache controller.
// slave = cache controller view, master = requester/RAM environment view.
interface cache_ctrl_dm_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              flush_req;
  logic              busy;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, flush_req, mem_rdata,
    output req_ready, busy, resp_valid, resp_data, resp_hit,
           mem_addr, mem_we, mem_wdata, hit_count, miss_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, flush_req, mem_rdata,
    input  req_ready, busy, resp_valid, resp_data, resp_hit,
           mem_addr, mem_we, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-back, write-allocate cache controller in front of a
// synchronous single-port RAM, with saturating hit/miss counters and a flush command.
module cache_ctrl_dm #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 8
) (
  input logic           CLOCK_50,
  input logic           RESET,
  cache_ctrl_dm_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WB, S_FETCH, S_FILL, S_FLUSH
  } state_t;

  state_t              state;
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [INDEX_W-1:0]  flush_idx;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_data;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign bus.req_ready = (state == S_IDLE) && !bus.flush_req;
  assign bus.busy      = (state != S_IDLE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // The line array is only written on a write hit (COMPARE) or on a fill.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    arr_we   = 1'b0;
    arr_data = wdata_q;
    if (state == S_COMPARE && hit && we_q) begin
      arr_we = 1'b1;
    end else if (state == S_FILL) begin
      arr_we   = 1'b1;
      arr_data = we_q ? wdata_q : bus.mem_rdata;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone says whether a line means anything.
  always_ff @(posedge CLOCK_50) begin
    if (arr_we) begin
      data_mem[idx] <= arr_data;
      tag_mem[idx]  <= tag;
    end
  end

  // RAM port is decoded from registered state only, so it drops the instant RESET rises.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = data_mem[idx];
    case (state)
      S_WB: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_mem[idx], idx};
      end
      S_FLUSH: begin
        bus.mem_we    = valid_q[flush_idx] && dirty_q[flush_idx];
        bus.mem_addr  = {tag_mem[flush_idx], flush_idx};
        bus.mem_wdata = data_mem[flush_idx];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state          <= S_IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      flush_idx      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_hit   <= 1'b0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.flush_req) begin
            flush_idx <= '0;
            state     <= S_FLUSH;
          end else if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit) begin
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b1;
            bus.resp_data  <= we_q ? wdata_q : data_mem[idx];
            bus.hit_count  <= sat_inc(bus.hit_count);
            if (we_q) dirty_q[idx] <= 1'b1;
            state <= S_IDLE;
          end else begin
            bus.miss_count <= sat_inc(bus.miss_count);
            state <= (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_FETCH: state <= S_FILL;
        S_FILL: begin
          valid_q[idx]   <= 1'b1;
          dirty_q[idx]   <= we_q;
          bus.resp_valid <= 1'b1;
          bus.resp_hit   <= 1'b0;
          bus.resp_data  <= we_q ? wdata_q : bus.mem_rdata;
          state          <= S_IDLE;
        end
        S_FLUSH: begin
          valid_q[flush_idx] <= 1'b0;
          dirty_q[flush_idx] <= 1'b0;
          flush_idx          <= flush_idx + 1'b1;
          if (flush_idx == {INDEX_W{1'b1}}) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm: a default instance plus a CNT_W=2 twin fed the
// same requests, each with its own synchronous RAM preloaded with mem[a] = a + 0x10.
`timescale 1ns/1ps
module tb_cache_ctrl_dm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_dm_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(8)) bus ();
  cache_ctrl_dm_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(2)) sbus ();

  cache_ctrl_dm #(.ADDR_W(5), .DATA_W(8), .INDEX_W(3), .CNT_W(8)) u_dut (
    .CLOCK_50(clk), .RESET(rst), .bus(bus)
  );
  cache_ctrl_dm #(.ADDR_W(5), .DATA_W(8), .INDEX_W(3), .CNT_W(2)) u_sat (
    .CLOCK_50(clk), .RESET(rst), .bus(sbus)
  );

  assign sbus.req_valid = bus.req_valid;
  assign sbus.req_we    = bus.req_we;
  assign sbus.req_addr  = bus.req_addr;
  assign sbus.req_wdata = bus.req_wdata;
  assign sbus.flush_req = bus.flush_req;

  logic [7:0] ram  [32];
  logic [7:0] sram [32];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  always @(posedge clk) begin
    if (sbus.mem_we) sram[sbus.mem_addr] <= sbus.mem_wdata;
    sbus.mem_rdata <= sram[sbus.mem_addr];
  end

  int         we_pulses = 0;
  int         resp_pulses = 0;
  logic [4:0] last_we_addr;
  logic [7:0] last_we_data;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_pulses    <= we_pulses + 1;
      last_we_addr <= bus.mem_addr;
      last_we_data <= bus.mem_wdata;
    end
    if (bus.resp_valid) resp_pulses <= resp_pulses + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic       log_we   [16];
  logic [4:0] log_addr [16];
  logic [7:0] log_wd   [16];

  // Issues one request and reports the response cycle counted from the acceptance edge.
  task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                        output int cyc, output logic [7:0] data, output logic hit);
    cyc  = -1;
    data = '0;
    hit  = 1'b0;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wd;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      log_we[j]   = bus.mem_we;
      log_addr[j] = bus.mem_addr;
      log_wd[j]   = bus.mem_wdata;
      if (bus.resp_valid) begin
        cyc  = j + 1;
        data = bus.resp_data;
        hit  = bus.resp_hit;
        break;
      end
    end
    if (cyc < 0) check("resp_timeout", 0, 1);
    @(negedge clk);
    check("resp_one_cycle", bus.resp_valid, 0);
    check("resp_data_held", bus.resp_data, data);
  endtask

  int         cyc, w0, r0, nb;
  logic [7:0] d;
  logic       h;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.flush_req = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ram[a]  = 8'(a + 8'h10);
      sram[a] = 8'(a + 8'h10);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_hit_count", bus.hit_count, 0);
    check("rst_miss_count", bus.miss_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_we", bus.mem_we, 0);

    // Clean read miss
    w0 = we_pulses;
    do_req(1'b0, 5'h05, 8'h00, cyc, d, h);
    check("rd05_miss_cycles", cyc, 4);
    check("rd05_miss_data", d, 8'h15);
    check("rd05_miss_hit", h, 0);
    check("rd05_fetch_addr", log_addr[1], 5'h05);
    check("rd05_fetch_we", log_we[1], 0);
    check("rd05_no_mem_write", we_pulses - w0, 0);
    check("rd05_miss_count", bus.miss_count, 1);

    // Read hit
    do_req(1'b0, 5'h05, 8'h00, cyc, d, h);
    check("rd05_hit_cycles", cyc, 2);
    check("rd05_hit_data", d, 8'h15);
    check("rd05_hit_hit", h, 1);
    check("rd05_hit_count", bus.hit_count, 1);

    // Write hit, data echoed from the latched value
    do_req(1'b1, 5'h05, 8'hAA, cyc, d, h);
    check("wr05_cycles", cyc, 2);
    check("wr05_data", d, 8'hAA);
    check("wr05_hit", h, 1);
    check("wr05_no_mem_write", we_pulses - w0, 0);

    // Conflict read on index 5 evicts dirty 0x05
    w0 = we_pulses;
    do_req(1'b0, 5'h0D, 8'h00, cyc, d, h);
    check("rd0d_cycles", cyc, 5);
    check("rd0d_data", d, 8'h1D);
    check("rd0d_hit", h, 0);
    check("rd0d_wb_we", log_we[1], 1);
    check("rd0d_wb_addr", log_addr[1], 5'h05);
    check("rd0d_wb_data", log_wd[1], 8'hAA);
    check("rd0d_fetch_we", log_we[2], 0);
    check("rd0d_fetch_addr", log_addr[2], 5'h0D);
    check("rd0d_wb_pulses", we_pulses - w0, 1);
    check("rd0d_ram5", ram[5], 8'hAA);

    // Write miss on an empty line
    w0 = we_pulses;
    do_req(1'b1, 5'h13, 8'h3C, cyc, d, h);
    check("wr13_cycles", cyc, 4);
    check("wr13_data", d, 8'h3C);
    check("wr13_hit", h, 0);
    check("wr13_no_mem_write", we_pulses - w0, 0);
    check("wr13_miss_count", bus.miss_count, 3);

    // Flush, with a competing request that must lose
    @(negedge clk);
    bus.flush_req = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'h05;
    #1;
    check("flush_ready_low", bus.req_ready, 0);
    w0 = we_pulses;
    r0 = resp_pulses;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    bus.req_valid = 1'b0;
    nb = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      else break;
    end
    check("flush_cycles", nb, 8);
    check("flush_wb_pulses", we_pulses - w0, 1);
    check("flush_wb_addr", last_we_addr, 5'h13);
    check("flush_wb_data", last_we_data, 8'h3C);
    check("flush_no_resp", resp_pulses - r0, 0);
    check("flush_hit_count", bus.hit_count, 2);
    check("flush_miss_count", bus.miss_count, 3);
    check("flush_ram13", ram[5'h13], 8'h3C);

    // Flushed line misses and reads back the written-back value
    do_req(1'b0, 5'h13, 8'h00, cyc, d, h);
    check("rd13_cycles", cyc, 4);
    check("rd13_data", d, 8'h3C);
    check("rd13_hit", h, 0);

    // Three more hits: five hits total, four misses
    for (int k = 0; k < 3; k++) begin
      do_req(1'b0, 5'h13, 8'h00, cyc, d, h);
      check("rd13_rehit", h, 1);
      check("rd13_rehit_data", d, 8'h3C);
    end
    check("hit_count_5", bus.hit_count, 5);
    check("miss_count_4", bus.miss_count, 4);
    check("sat_hit_count", sbus.hit_count, 3);
    check("sat_miss_count", sbus.miss_count, 3);

    // Reset while a clean miss is in FETCH
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'h0D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    w0 = we_pulses;
    r0 = resp_pulses;
    @(negedge clk);
    @(negedge clk);
    check("abort_fetch_addr", bus.mem_addr, 5'h0D);
    rst = 1'b1;
    #1;
    check("abort_busy_drop", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_mem_write", we_pulses - w0, 0);
    check("abort_no_resp", resp_pulses - r0, 0);
    check("abort_hit_count", bus.hit_count, 0);
    check("abort_miss_count", bus.miss_count, 0);
    check("abort_sat_hit_count", sbus.hit_count, 0);

    do_req(1'b0, 5'h0D, 8'h00, cyc, d, h);
    check("post_rst_cycles", cyc, 4);
    check("post_rst_hit", h, 0);
    check("post_rst_data", d, 8'h1D);
    check("post_rst_miss_count", bus.miss_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end
endmodule

// File: doc/cache_ctrl_dm.md
Name: cache_ctrl_dm

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache controller.
- Sits between a switch/HEX-driven requester and a synchronous single-port RAM. It replaces the fixed 32x8 cache array of the previous lab top level.
- Tracks valid/dirty/tag per line, counts hits and misses for HEX display, and supports a whole-cache flush command.

Parameters:
- ADDR_W, 5: word address width.
- DATA_W, 8: data word width.
- INDEX_W, 3: line index width; number of lines = 2**INDEX_W; tag width = ADDR_W-INDEX_W (must be >=1).
- CNT_W, 8: width of the hit and miss counters.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  high only in IDLE with flush_req low.
- flush_req  in  1  start a flush; sampled in IDLE only.
- busy  out  1  high whenever state != IDLE.
- resp_valid  out  1  one-cycle pulse, registered.
- resp_data  out  DATA_W  read data, or write data echoed for writes; held until the next response.
- resp_hit  out  1  registered with resp_valid; 1 = hit.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; all valid and dirty bits = 0.
  - resp_valid = 0, resp_data = 0, resp_hit = 0.
  - hit_count = miss_count = 0; flush index = 0.
  - Tag/data arrays need not reset.
  - Reset mid-miss or mid-flush aborts immediately; no further mem_we is issued.
- State IDLE:
  - flush_req = 1 -> FLUSH; flush takes priority over req_valid in the same cycle.
  - Otherwise req_valid = 1 -> latch we/addr/wdata, go to COMPARE.
- State COMPARE: hit = valid[idx] and tag[idx] == latched tag.
  - Read hit: resp_data = line data, resp_hit = 1, resp_valid pulse, hit_count+1, -> IDLE.
  - Write hit: line data = wdata, dirty = 1, resp_data = wdata, resp_valid pulse, hit_count+1, -> IDLE.
  - Miss: miss_count+1. If valid and dirty -> WB, else -> FETCH.
- State WB: mem_we = 1, mem_addr = {victim tag, idx}, mem_wdata = victim data. Next state FETCH.
- State FETCH: mem_we = 0, mem_addr = latched addr. Next state FILL.
- State FILL: capture mem_rdata.
  - Read: line = mem_rdata, dirty = 0.
  - Write: line = wdata, dirty = 1.
  - In both cases: valid = 1, tag updated, resp_hit = 0, resp_valid pulse, resp_data = read value or wdata, -> IDLE.
- State FLUSH (one line per cycle, i = 0..2**INDEX_W-1):
  - If valid and dirty: mem_we = 1, write back {tag, i}.
  - Clear valid[i] and dirty[i].
  - After the last line: -> IDLE; no resp_valid; counters unchanged.
- mem_we is 0 in all states except WB and FLUSH-dirty. mem_addr is don't-care when mem_we = 0 and state != FETCH.
- Latency, measured from the acceptance edge to the cycle resp_valid is high:
  - Hit: 2 cycles.
  - Clean miss: 4 cycles.
  - Dirty miss: 5 cycles.
- Requests are not accepted while busy. req_addr/req_wdata changes after acceptance have no effect.
- Counters saturate at 2**CNT_W-1; no wrap.
- Index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].

Test Plan (defaults; RAM preloaded mem[a] = a + 0x10):
- Reset, then read 0x05: miss -> FETCH mem_addr = 0x05; resp_data = 0x15, resp_hit = 0, resp_valid 4 cycles after acceptance; miss_count = 1.
- Read 0x05 again: resp_data = 0x15, resp_hit = 1 after 2 cycles; hit_count = 1; no mem access.
- Write 0x05 <= 0xAA (hit), then read 0x0D (same index 5, tag 1): WB cycle with mem_we = 1, mem_addr = 0x05, mem_wdata = 0xAA; then resp_data = 0x1D after 5 cycles.
- Write miss 0x13 <= 0x3C: line 3 filled, dirty = 1, resp_data = 0x3C. Then flush_req: exactly one mem_we pulse (addr 0x13, data 0x3C) over 8 FLUSH cycles. Next read of 0x13 misses and returns 0x3C.
- Assert RESET during FETCH of a miss: resp_valid never pulses; counters = 0; a subsequent read of the same address is a miss.
- With CNT_W = 2, issue 5 hits: hit_count sticks at 3.
